// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : Execute-side branch resolution. Queues every fetch prediction,
//             checks the oldest one against the actual outcome in execute,
//             drives the fetch redirect interface and the predictor update.
//  Option   : BRU_STATS_EN - enables 16-bit saturating branch/mispredict
//             counters; when undefined the stat ports are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   // fetch-side prediction push
   input  logic                       f_valid_i,
   input  logic [PC_W-1:0]            f_pc_i,
   input  logic                       f_pred_i,
   input  logic                       f_taken_i,
   input  logic [PC_W-1:0]            f_pred_pc_i,
   output logic                       full_o,
   // execute-side resolution pop
   input  logic                       ex_valid_i,
   input  logic                       ex_is_branch_i,
   input  logic                       ex_taken_i,
   input  logic [PC_W-1:0]            ex_target_i,
   input  logic                       exc_flush_i,
   // fetch redirect
   output logic                       dcsn_ok_o,
   output logic                       dcsn_o,
   output logic [PC_W-1:0]            restore_pc_o,
   output logic [PC_W-1:0]            alu_pc_o,
   // predictor training
   output logic                       upd_valid_o,
   output logic [PC_W-1:0]            upd_pc_o,
   output logic                       upd_taken_o,
   output logic [PC_W-1:0]            upd_target_o,
   // status
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       err_o,
   output logic [15:0]                stat_branches_o,
   output logic [15:0]                stat_mispred_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [0:0] {
      NORMAL   = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t            state;

   // prediction queue storage
   logic [PC_W-1:0]   q_pc      [DEPTH];
   logic              q_pred    [DEPTH];
   logic              q_taken   [DEPTH];
   logic [PC_W-1:0]   q_pred_pc [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              empty;
   logic              full;
   logic              push_req;
   logic              pop_req;
   logic              push;
   logic              pop;
   logic              overflow;
   logic              underflow;
   logic              mispred;
   logic              ptaken;
   logic [PC_W-1:0]   head_pc;
   logic [PC_W-1:0]   head_pred_pc;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign full_o  = full;
   assign count_o = count;

   // decode push/pop/mispredict for the current cycle
   always_comb begin
      head_pc      = q_pc[rd_ptr];
      head_pred_pc = q_pred_pc[rd_ptr];
      ptaken       = q_pred[rd_ptr] & q_taken[rd_ptr];
      // wrong-path traffic during REDIRECT is silently discarded
      push_req     = f_valid_i  & (state == NORMAL);
      pop_req      = ex_valid_i & (state == NORMAL);
      pop          = pop_req & ~empty;
      underflow    = pop_req & empty;
      mispred      = 1'b0;
      if (pop) begin
         if (ex_is_branch_i) begin
            if (ex_taken_i != ptaken)
               mispred = 1'b1;
            else if (ex_taken_i && ptaken && (ex_target_i != head_pred_pc))
               mispred = 1'b1;
         end else if (ptaken) begin
            mispred = 1'b1;
         end
      end
      // a push alongside a mispredict pop is younger, hence wrong-path
      push         = push_req & (~full | pop) & ~mispred;
      overflow     = push_req & full & ~pop;
   end

   // queue payload writes (no reset needed; pointers define validity)
   always_ff @(posedge clk_i) begin
      if (push) begin
         q_pc[wr_ptr]      <= f_pc_i;
         q_pred[wr_ptr]    <= f_pred_i;
         q_taken[wr_ptr]   <= f_taken_i;
         q_pred_pc[wr_ptr] <= f_pred_pc_i;
      end
   end

   // queue pointers, occupancy and sticky error flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_o  <= 1'b0;
      end else if (exc_flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         err_o <= err_o | overflow | underflow;
         if (mispred) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
               count <= count + CNT_W'(1);
            else if (pop && !push)
               count <= count - CNT_W'(1);
         end
      end
   end

   // redirect FSM with registered one-cycle decision outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= NORMAL;
         dcsn_ok_o    <= 1'b1;
         dcsn_o       <= 1'b0;
         restore_pc_o <= '0;
         alu_pc_o     <= '0;
      end else if (exc_flush_i) begin
         state     <= NORMAL;
         dcsn_ok_o <= 1'b1;
         dcsn_o    <= 1'b0;
      end else begin
         dcsn_ok_o <= 1'b1;
         dcsn_o    <= 1'b0;
         case (state)
            NORMAL: begin
               if (mispred) begin
                  state     <= REDIRECT;
                  dcsn_ok_o <= 1'b0;
                  if (!ex_is_branch_i || !ex_taken_i) begin
                     dcsn_o       <= 1'b1;
                     restore_pc_o <= head_pc + PC_W'(4);
                  end else begin
                     alu_pc_o <= ex_target_i;
                  end
               end
            end
            REDIRECT: state <= NORMAL;
            default:  state <= NORMAL;
         endcase
      end
   end

   // predictor training strobe for every resolved branch
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         upd_valid_o  <= 1'b0;
         upd_pc_o     <= '0;
         upd_taken_o  <= 1'b0;
         upd_target_o <= '0;
      end else begin
         upd_valid_o <= pop & ex_is_branch_i & ~exc_flush_i;
         if (pop && ex_is_branch_i && !exc_flush_i) begin
            upd_pc_o     <= head_pc;
            upd_taken_o  <= ex_taken_i;
            upd_target_o <= ex_target_i;
         end
      end
   end

`ifdef BRU_STATS_EN
   logic [15:0] stat_br;
   logic [15:0] stat_mp;

   // saturating statistics; survive exception flushes, cleared by reset only
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_br <= '0;
         stat_mp <= '0;
      end else if (!exc_flush_i) begin
         if (pop && ex_is_branch_i && (stat_br != 16'hFFFF))
            stat_br <= stat_br + 16'd1;
         if (mispred && (stat_mp != 16'hFFFF))
            stat_mp <= stat_mp + 16'd1;
      end
   end

   assign stat_branches_o = stat_br;
   assign stat_mispred_o  = stat_mp;
`else
   assign stat_branches_o = 16'd0;
   assign stat_mispred_o  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Purpose  : Directed self-checking bench for branch_resolve_unit.
//             Honours BRU_STATS_EN for the statistics expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        f_pred;
   logic        f_taken;
   logic [31:0] f_pred_pc;
   logic        full;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        exc_flush;
   logic        dcsn_ok;
   logic        dcsn;
   logic [31:0] restore_pc;
   logic [31:0] alu_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [2:0]  count;
   logic        err;
   logic [15:0] stat_branches;
   logic [15:0] stat_mispred;

   int checks = 0;
   int errors = 0;

   branch_resolve_unit #(.DEPTH(4), .PC_W(32)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .f_valid_i       (f_valid),
      .f_pc_i          (f_pc),
      .f_pred_i        (f_pred),
      .f_taken_i       (f_taken),
      .f_pred_pc_i     (f_pred_pc),
      .full_o          (full),
      .ex_valid_i      (ex_valid),
      .ex_is_branch_i  (ex_is_branch),
      .ex_taken_i      (ex_taken),
      .ex_target_i     (ex_target),
      .exc_flush_i     (exc_flush),
      .dcsn_ok_o       (dcsn_ok),
      .dcsn_o          (dcsn),
      .restore_pc_o    (restore_pc),
      .alu_pc_o        (alu_pc),
      .upd_valid_o     (upd_valid),
      .upd_pc_o        (upd_pc),
      .upd_taken_o     (upd_taken),
      .upd_target_o    (upd_target),
      .count_o         (count),
      .err_o           (err),
      .stat_branches_o (stat_branches),
      .stat_mispred_o  (stat_mispred)
   );

   always #5 clk = ~clk;

   // watchdog: the directed sequence is a few dozen cycles long
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic pred, input logic tk, input logic [31:0] ppc);
      f_valid = 1'b1; f_pc = pc; f_pred = pred; f_taken = tk; f_pred_pc = ppc;
      tick();
      f_valid = 1'b0;
   endtask

   task automatic pop(input logic br, input logic tk, input logic [31:0] tgt);
      ex_valid = 1'b1; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
      tick();
      ex_valid = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_br;
      logic [15:0] exp_mp;
      rst = 1'b1;
      f_valid = 0; f_pc = '0; f_pred = 0; f_taken = 0; f_pred_pc = '0;
      ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_target = '0;
      exc_flush = 0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      check("rst_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("rst_dcsn", 32'(dcsn), 32'd0);
      check("rst_restore_pc", restore_pc, 32'h0);
      check("rst_alu_pc", alu_pc, 32'h0);
      check("rst_upd_valid", 32'(upd_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_full", 32'(full), 32'd0);

      // fill to capacity, then overflow
      for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd4);
      check("fill_err", 32'(err), 32'd0);
      push(32'h1010, 1'b0, 1'b0, 32'h0);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_count", 32'(count), 32'd4);
      rst = 1'b1; tick(); rst = 1'b0;
      check("rst2_count", 32'(count), 32'd0);
      check("rst2_err", 32'(err), 32'd0);

      // correct taken prediction
      push(32'h1000, 1'b1, 1'b1, 32'h2000);
      pop(1'b1, 1'b1, 32'h2000);
      check("hit_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("hit_upd_valid", 32'(upd_valid), 32'd1);
      check("hit_upd_pc", upd_pc, 32'h1000);
      check("hit_upd_taken", 32'(upd_taken), 32'd1);
      check("hit_upd_target", upd_target, 32'h2000);
      check("hit_count", 32'(count), 32'd0);
      tick();
      check("hit_upd_pulse", 32'(upd_valid), 32'd0);

      // predicted taken, actually not taken
      push(32'h1004, 1'b1, 1'b1, 32'h3000);
      pop(1'b1, 1'b0, 32'h1008);
      check("nt_dcsn_ok", 32'(dcsn_ok), 32'd0);
      check("nt_dcsn", 32'(dcsn), 32'd1);
      check("nt_restore_pc", restore_pc, 32'h1008);
      check("nt_count", 32'(count), 32'd0);
      check("nt_upd_taken", 32'(upd_taken), 32'd0);
      tick();
      check("nt_dcsn_pulse", 32'(dcsn_ok), 32'd1);

      // not predicted, actually taken; younger entries discarded
      push(32'h1000, 1'b0, 1'b0, 32'h0);
      push(32'h1004, 1'b0, 1'b0, 32'h0);
      push(32'h1008, 1'b0, 1'b0, 32'h0);
      check("tk_pre_count", 32'(count), 32'd3);
      pop(1'b1, 1'b1, 32'h4000);
      check("tk_dcsn_ok", 32'(dcsn_ok), 32'd0);
      check("tk_dcsn", 32'(dcsn), 32'd0);
      check("tk_alu_pc", alu_pc, 32'h4000);
      check("tk_count", 32'(count), 32'd0);
      // wrong-path push and pop during REDIRECT: dropped, no error
      f_valid = 1'b1; f_pc = 32'h5000; f_pred = 0; f_taken = 0;
      ex_valid = 1'b1; ex_is_branch = 1'b1; ex_taken = 1'b0;
      tick();
      f_valid = 1'b0; ex_valid = 1'b0;
      check("redir_count", 32'(count), 32'd0);
      check("redir_err", 32'(err), 32'd0);
      check("redir_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("redir_upd_valid", 32'(upd_valid), 32'd0);
      push(32'h5004, 1'b0, 1'b0, 32'h0);
      check("post_redir_count", 32'(count), 32'd1);
      pop(1'b0, 1'b0, 32'h0);
      check("nb_count", 32'(count), 32'd0);
      check("nb_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("nb_upd_valid", 32'(upd_valid), 32'd0);

      // non-branch predicted taken; fall-through wraps
      push(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0100);
      pop(1'b0, 1'b0, 32'h0);
      check("wrap_dcsn_ok", 32'(dcsn_ok), 32'd0);
      check("wrap_dcsn", 32'(dcsn), 32'd1);
      check("wrap_restore_pc", restore_pc, 32'h0);
      check("wrap_upd_valid", 32'(upd_valid), 32'd0);
      tick();

      // simultaneous push and correct pop keeps occupancy
      push(32'hA000, 1'b0, 1'b0, 32'h0);
      f_valid = 1'b1; f_pc = 32'hA004; f_pred = 0; f_taken = 0;
      pop(1'b1, 1'b0, 32'hA004);
      f_valid = 1'b0;
      check("pp_count", 32'(count), 32'd1);
      check("pp_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("pp_upd_pc", upd_pc, 32'hA000);
      pop(1'b0, 1'b0, 32'h0);
      check("pp_drain", 32'(count), 32'd0);

      // taken both ways but target differs
      push(32'h8000, 1'b1, 1'b1, 32'h9000);
      pop(1'b1, 1'b1, 32'h9004);
      check("tgt_dcsn_ok", 32'(dcsn_ok), 32'd0);
      check("tgt_dcsn", 32'(dcsn), 32'd0);
      check("tgt_alu_pc", alu_pc, 32'h9004);
      tick();

      // exception flush overrides a simultaneous mispredict pop
      push(32'h6000, 1'b0, 1'b0, 32'h0);
      push(32'h6004, 1'b0, 1'b0, 32'h0);
      push(32'h6008, 1'b0, 1'b0, 32'h0);
      exc_flush = 1'b1; f_valid = 1'b1; f_pc = 32'h600C;
      pop(1'b1, 1'b1, 32'h7000);
      exc_flush = 1'b0; f_valid = 1'b0;
      check("flush_count", 32'(count), 32'd0);
      check("flush_dcsn_ok", 32'(dcsn_ok), 32'd1);
      check("flush_upd_valid", 32'(upd_valid), 32'd0);
      check("flush_err", 32'(err), 32'd0);

      // branch pops: 0x1000 hit, 0x1004 nt, 0x1000 tk, 0xA000, 0x8000
      // mispredicts: 0x1004, 0x1000, 0xFFFFFFFC, 0x8000
`ifdef BRU_STATS_EN
      exp_br = 16'd5;
      exp_mp = 16'd4;
`else
      exp_br = 16'd0;
      exp_mp = 16'd0;
`endif
      check("stat_branches", 32'(stat_branches), 32'(exp_br));
      check("stat_mispred", 32'(stat_mispred), 32'(exp_mp));

      // pop on an empty queue sets the sticky error
      pop(1'b1, 1'b0, 32'h0);
      check("udf_err", 32'(err), 32'd1);
      check("udf_count", 32'(count), 32'd0);
      check("udf_dcsn_ok", 32'(dcsn_ok), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch stage's prediction path.
- Records every prediction fetch makes (pc, pred, taken, pred_pc) in an in-order queue.
- Pops one entry as each instruction resolves in execute and compares the prediction with the actual outcome.
- Drives the fetch redirect interface (dcsn_ok/dcsn/restore_pc/alu_pc) and a predictor-training update port.

Parameters:
- DEPTH, 4, in-flight prediction entries (power of 2, >=2)
- PC_W, 32, PC width

Ports:
- clk_i  in  1  clock, all state on posedge
- rst_i  in  1  synchronous, active-high reset
- f_valid_i  in  1  fetch issued an instruction this cycle (push)
- f_pc_i  in  PC_W  fetched pc
- f_pred_i  in  1  predictor hit
- f_taken_i  in  1  predicted taken
- f_pred_pc_i  in  PC_W  predicted target
- full_o  out  1  queue full; fetch stall request
- ex_valid_i  in  1  oldest instruction resolves this cycle (pop)
- ex_is_branch_i  in  1  resolving instruction is a branch/jump
- ex_taken_i  in  1  actual direction
- ex_target_i  in  PC_W  actual taken target
- exc_flush_i  in  1  exception/iret flush
- dcsn_ok_o  out  1  1 = no redirect
- dcsn_o  out  1  when dcsn_ok_o=0: 1 = use restore_pc_o, 0 = use alu_pc_o
- restore_pc_o  out  PC_W  fall-through pc (branch pc + 4)
- alu_pc_o  out  PC_W  actual taken target
- upd_valid_o  out  1  predictor update strobe
- upd_pc_o  out  PC_W  branch pc
- upd_taken_o  out  1  actual direction
- upd_target_o  out  PC_W  actual target
- count_o  out  $clog2(DEPTH)+1  entries held
- err_o  out  1  sticky overflow/underflow flag
- stat_branches_o  out  16  see optional feature
- stat_mispred_o  out  16  see optional feature

Behaviour:
- Reset values: dcsn_ok_o=1, dcsn_o=0, every PC output 0, upd_valid_o=0, count_o=0, err_o=0, stats 0, state NORMAL, queue empty. Reset mid-operation discards all entries.
- Queue: circular FIFO; wr/rd pointers wrap at DEPTH. full_o = (count==DEPTH), combinational.
- Push: f_valid_i in NORMAL state and (not full, or pop in same cycle). Push while full with no pop: entry dropped, err_o set.
- Pop: ex_valid_i with a non-empty queue. ex_valid_i on an empty queue: ignored, err_o set.
- Effective prediction of the head entry: ptaken = pred & taken.
- Mispredict conditions:
  - branch and ex_taken_i != ptaken;
  - branch, ex_taken_i=1, ptaken=1, ex_target_i != pred_pc;
  - non-branch with ptaken=1.
- Redirect on mispredict; outputs are registered and valid the cycle after the pop, for exactly 1 cycle:
  - dcsn_ok_o=0.
  - Actual not-taken, or non-branch: dcsn_o=1, restore_pc_o = pc + 4, modulo 2^PC_W.
  - Actual taken: dcsn_o=0, alu_pc_o = ex_target_i.
  - The whole queue is cleared at the same edge; younger entries are wrong-path.
- FSM:
  - NORMAL -> REDIRECT on a mispredict pop.
  - REDIRECT -> NORMAL unconditionally after 1 cycle.
  - In REDIRECT, f_valid_i pushes and ex_valid_i pops are dropped without setting err_o; those instructions are wrong-path.
- Predictor update: every pop with ex_is_branch_i=1, mispredicted or not, gives upd_valid_o=1 for 1 cycle, 1-cycle latency, carrying the head pc, ex_taken_i and ex_target_i.
- exc_flush_i (highest priority, over push/pop/mispredict in the same cycle):
  - Clears the queue and returns the FSM to NORMAL.
  - No dcsn pulse and no upd pulse for that cycle; fetch redirect is owned by the exception path.
- Simultaneous push and pop in NORMAL without mispredict: count unchanged. A push in the same cycle as a mispredict pop is dropped.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined: 16-bit saturating counters (hold at 0xFFFF).
  - stat_branches_o increments on each branch pop.
  - stat_mispred_o increments on each mispredict pop.
  - Both cleared by rst_i only; not cleared by exc_flush_i.
- Undefined: both ports tied to 0; no counter flops.

Test Plan:
- Reset then 4 pushes (pc 0x1000..0x100C, no pred) with no pops -> full_o=1, count_o=4; a 5th push gives err_o=1 and count stays 4.
- Push pc 0x1000 (pred=1, taken=1, pred_pc 0x2000); pop with branch, taken, target 0x2000 -> dcsn_ok_o stays 1; next cycle upd_valid_o=1 with upd_pc_o 0x1000 and upd_target_o 0x2000.
- Push pc 0x1004 (predicted taken to 0x3000); pop with branch, not-taken -> next cycle dcsn_ok_o=0, dcsn_o=1, restore_pc_o=0x1008; queue count 0.
- Push 0x1000 (no pred) plus 2 younger entries; pop with branch, taken, target 0x4000 -> dcsn_ok_o=0, dcsn_o=0, alu_pc_o=0x4000; count_o=0; a push in the REDIRECT cycle is dropped; a push in the following cycle is accepted (count_o=1).
- Push 0xFFFFFFFC (predicted taken); pop with non-branch -> restore_pc_o=0x00000000 (wrap), dcsn_o=1, upd_valid_o stays 0.
- 3 entries queued; exc_flush_i asserted together with a mispredict pop -> count_o=0, dcsn_ok_o stays 1, upd_valid_o=0. With BRU_STATS_EN: 3 branch pops including 1 mispredict -> stat_branches_o=3, stat_mispred_o=1.
